mod_addsub_pipe: RTL and testbench

Parametrised, pipelined modular adder/subtractor for the NTT butterfly datapath. Computes (a + b) mod q or (a - b) mod q per transaction, selected by an op bit, with valid/ready handshakes and full backpressure. A tag field rides alongside each operand pair so downstream logic can match results to coefficient indices. Replaces single-mode, single-width combinational modular subtraction in the butterfly.

---
 rtl/ntt_pkg.sv | 11 +
 rtl/mod_correct_step.sv | 27 ++
 rtl/mod_addsub_pipe.sv | 141 ++++++++++++++
 tb/tb_mod_addsub_pipe.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared constants for the NTT butterfly datapath: default coefficient width,
// default modulus and the add/subtract op encoding.
package ntt_pkg;

    localparam int   NTT_WIDTH = 12;
    localparam int   NTT_Q     = 3329;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/mod_correct_step.sv
// Combinational modular correction: folds a WIDTH+1-bit raw sum/difference
// back into 0..q-1 with one conditional subtract (add) or add (sub) of q.
module mod_correct_step
    import ntt_pkg::*;
#(
    parameter int WIDTH = NTT_WIDTH
) (
    input  logic [WIDTH:0]   in_s,
    input  logic             in_borrow,
    input  logic             in_op,
    input  logic [WIDTH-1:0] in_q,
    output logic [WIDTH-1:0] out_res
);

    always_comb begin
        out_res = in_s[WIDTH-1:0];
        if (in_op == OP_ADD) begin
            // Subtracting in WIDTH bits is exact here: the true result is < q.
            if (in_s >= {1'b0, in_q}) begin
                out_res = in_s[WIDTH-1:0] - in_q;
            end
        end else if (in_borrow) begin
            out_res = in_s[WIDTH-1:0] + in_q;
        end
    end

endmodule

// File: rtl/mod_addsub_pipe.sv
// Two-stage pipelined modular adder/subtractor with valid/ready on both sides
// and a pass-through tag. Define MOD_ADDSUB_RANGE_CHECK_EN to add err_sticky.
module mod_addsub_pipe
    import ntt_pkg::*;
#(
    parameter int WIDTH = NTT_WIDTH,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_op,
    input  logic [WIDTH-1:0] in_q,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic [TAG_W-1:0] out_tag
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
    ,
    output logic             err_sticky
`endif
);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH:0]   s1_sum_q, s1_sum_d;
    logic             s1_borrow_q, s1_borrow_d;
    logic [WIDTH-1:0] s1_mod_q, s1_mod_d;
    logic             s1_op_q, s1_op_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_res_q, s2_res_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

    logic             s2_load;
    logic             in_fire;
    logic [WIDTH-1:0] corr_res;

    mod_correct_step #(.WIDTH(WIDTH)) u_correct (
        .in_s      (s1_sum_q),
        .in_borrow (s1_borrow_q),
        .in_op     (s1_op_q),
        .in_q      (s1_mod_q),
        .out_res   (corr_res)
    );

    always_comb begin
        s2_load  = ~s2_valid_q | out_ready;
        in_ready = ~s1_valid_q | s2_load;
        in_fire  = in_valid & in_ready;

        s1_valid_d  = s1_valid_q;
        s1_sum_d    = s1_sum_q;
        s1_borrow_d = s1_borrow_q;
        s1_mod_d    = s1_mod_q;
        s1_op_d     = s1_op_q;
        s1_tag_d    = s1_tag_q;
        s2_valid_d  = s2_valid_q;
        s2_res_d    = s2_res_q;
        s2_tag_d    = s2_tag_q;

        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (in_fire) begin
            if (in_op == OP_SUB) begin
                s1_sum_d    = {1'b0, in_a} - {1'b0, in_b};
                s1_borrow_d = (in_a < in_b);
            end else begin
                s1_sum_d    = {1'b0, in_a} + {1'b0, in_b};
                s1_borrow_d = s1_sum_d[WIDTH];
            end
            s1_mod_d = in_q;
            s1_op_d  = in_op;
            s1_tag_d = in_tag;
        end

        // Output data only changes when a new result actually lands in S2.
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_res_d = corr_res;
                s2_tag_d = s1_tag_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sum_q    <= '0;
            s1_borrow_q <= 1'b0;
            s1_mod_q    <= '0;
            s1_op_q     <= 1'b0;
            s1_tag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_res_q    <= '0;
            s2_tag_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sum_q    <= s1_sum_d;
            s1_borrow_q <= s1_borrow_d;
            s1_mod_q    <= s1_mod_d;
            s1_op_q     <= s1_op_d;
            s1_tag_q    <= s1_tag_d;
            s2_valid_q  <= s2_valid_d;
            s2_res_q    <= s2_res_d;
            s2_tag_q    <= s2_tag_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_res   = s2_res_q;
    assign out_tag   = s2_tag_q;

`ifdef MOD_ADDSUB_RANGE_CHECK_EN
    logic err_sticky_q, err_sticky_d;

    always_comb begin
        err_sticky_d = err_sticky_q;
        if (in_fire && ((in_a >= in_q) || (in_b >= in_q) || (in_q < WIDTH'(2)))) begin
            err_sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky_q <= 1'b0;
        end else begin
            err_sticky_q <= err_sticky_d;
        end
    end

    assign err_sticky = err_sticky_q;
`endif

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Self-checking bench for mod_addsub_pipe (WIDTH=16): directed boundary cases,
// randomized backpressure traffic against a plain-arithmetic reference model.
module tb_mod_addsub_pipe;

    localparam int W  = 16;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_op;
    logic [W-1:0]  in_q;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_res;
    logic [TW-1:0] out_tag;
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
    logic          err_sticky;
`endif

    always #5 clk = ~clk;

    mod_addsub_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_q      (in_q),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_tag   (out_tag)
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
        ,
        .err_sticky(err_sticky)
`endif
    );

    typedef struct {
        logic [W-1:0]  res;
        logic [TW-1:0] tag;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    bit            check_lat = 0;
    bit            rand_ready = 0;
    bit            stall_prev = 0;
    bit            fired = 0;
    logic [W-1:0]  hold_res;
    logic [TW-1:0] hold_tag;
    logic [W-1:0]  cur_exp;

    // Reference: modular arithmetic on wide signed integers.
    function automatic logic [W-1:0] ref_model(input int unsigned a, input int unsigned b,
                                               input bit op, input int unsigned q);
        longint la, lb, lq, r;
        la = longint'(a);
        lb = longint'(b);
        lq = longint'(q);
        if (op) r = (la - lb) % lq;
        else    r = (la + lb) % lq;
        if (r < 0) r = r + lq;
        return W'(r);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: observe handshakes at negedge, then move to just after posedge.
    task automatic step();
        exp_t e;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (stall_prev) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_res", 32'(out_res), 32'(hold_res));
            check("stall_tag", 32'(out_tag), 32'(hold_tag));
        end
        fired = in_valid && in_ready;
        if (fired) sb.push_back('{cur_exp, in_tag, cyc});
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("res", 32'(out_res), 32'(e.res));
                check("tag", 32'(out_tag), 32'(e.tag));
                if (check_lat) check("latency", 32'(cyc - e.cyc), 32'd2);
            end
        end
        stall_prev = out_valid && !out_ready;
        hold_res   = out_res;
        hold_tag   = out_tag;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input int unsigned a, input int unsigned b, input bit op,
                        input int unsigned q, input logic [TW-1:0] tag, input logic [W-1:0] exp);
        in_valid = 1'b1;
        in_a     = W'(a);
        in_b     = W'(b);
        in_op    = op;
        in_q     = W'(q);
        in_tag   = tag;
        cur_exp  = exp;
        for (int i = 0; i < 64; i++) begin
            step();
            if (fired) break;
        end
        check("accept", 32'(fired), 32'd1);
    endtask

    task automatic drain();
        in_valid   = 1'b0;
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (sb.size() != 0) step();
        end
        check("drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        stall_prev = 1'b0;
        sb.delete();
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_res", 32'(out_res), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
        check("rst_err_sticky", 32'(err_sticky), 32'd0);
`endif
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned q, a, b;
        bit          op;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0;
        in_q = W'(3329); in_tag = '0; out_ready = 1'b1; cur_exp = '0;
        hold_res = '0; hold_tag = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Latency / back-to-back at q=3329.
        check_lat = 1'b1;
        send(3000, 400, 1'b0, 3329, 8'd1, 16'd71);
        send(5, 10, 1'b1, 3329, 8'd2, 16'd3324);
        drain();
        check_lat = 1'b0;

        // Boundaries.
        send(3328, 3328, 1'b0, 3329, 8'd3, 16'd3327);
        send(1664, 1665, 1'b0, 3329, 8'd4, 16'd0);
        send(0, 3328, 1'b1, 3329, 8'd5, 16'd1);
        send(77, 77, 1'b1, 3329, 8'd6, 16'd0);
        send(65534, 65534, 1'b0, 65535, 8'd7, 16'd65533);
        send(0, 65534, 1'b1, 65535, 8'd8, 16'd1);
        send(1, 1, 1'b0, 2, 8'd9, 16'd0);
        drain();

        // Per-transaction modulus.
        send(17 - 2, 15, 1'b0, 17, 8'd10, 16'd13);
        send(16, 15, 1'b0, 17, 8'd11, 16'd14);
        drain();
        send(17, 15, 1'b0, 17, 8'd12, 16'd15);
        send(60000, 6000, 1'b0, 65521, 8'd13, 16'd479);
        drain();

        // Backpressure: 8 random tagged transactions, tags 0..7.
        rand_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            q  = $urandom_range(2, 65535);
            a  = $urandom_range(0, q - 1);
            b  = $urandom_range(0, q - 1);
            op = 1'($urandom_range(0, 1));
            send(a, b, op, q, TW'(i), ref_model(a, b, op, q));
        end
        drain();

        // Longer random stream with input gaps and output stalls.
        rand_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                step();
            end
            q  = $urandom_range(2, 65535);
            a  = $urandom_range(0, q - 1);
            b  = $urandom_range(0, q - 1);
            op = 1'($urandom_range(0, 1));
            send(a, b, op, q, TW'($urandom), ref_model(a, b, op, q));
        end
        drain();

        // Reset with two transactions in flight: neither may appear.
        out_ready = 1'b0;
        send(10, 20, 1'b0, 3329, 8'hA0, 16'd30);
        send(50, 20, 1'b1, 3329, 8'hA1, 16'd30);
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_out_valid", 32'(out_valid), 32'd0);
            @(posedge clk);
            #1;
        end

`ifdef MOD_ADDSUB_RANGE_CHECK_EN
        in_valid = 1'b1; in_a = W'(3329); in_b = W'(1); in_op = 1'b0;
        in_q = W'(3329); in_tag = 8'hEE;
        @(negedge clk);
        check("err_before", 32'(err_sticky), 32'd0);
        check("err_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("err_held", 32'(err_sticky), 32'd1);
            @(posedge clk);
            #1;
        end
        do_reset();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
